multiword_add_ctrl: RTL and testbench

MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

---
 rtl/multiword_add_ctrl.sv | 121 ++++++++++++
 tb/tb_multiword_add_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_ctrl.sv
// Sequencer for one external N-bit adder: it adds or subtracts two W-bit operands
// one slice per cycle, LSB slice first, and chains the carry between slices.
module multiword_add_ctrl #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 sub_i,
  input  logic [N*WORDS-1:0]   op_a_i,
  input  logic [N*WORDS-1:0]   op_b_i,
  output logic [N-1:0]         add_a_o,
  output logic [N-1:0]         add_b_o,
  output logic                 add_c_o,
  input  logic [N-1:0]         add_s_i,
  input  logic                 add_c_i,
  output logic [N*WORDS-1:0]   sum_o,
  output logic                 carry_o,
  output logic                 ovf_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           cr_q, cr_d;
  logic           carry_q, carry_d;
  logic           ovf_q, ovf_d;
  logic           last;

  assign last = (idx_q == IW'(WORDS - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      cr_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cr_q    <= cr_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cr_d    = cr_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    add_a_o = '0;
    add_b_o = '0;
    add_c_o = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          // B is stored pre-inverted and cr seeded with sub_i, so A-B = A + ~B + 1.
          a_d     = op_a_i;
          b_d     = sub_i ? ~op_b_i : op_b_i;
          acc_d   = '0;
          idx_d   = '0;
          cr_d    = sub_i;
          state_d = CALC;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        add_a_o = a_q[int'(idx_q)*N +: N];
        add_b_o = b_q[int'(idx_q)*N +: N];
        add_c_o = cr_q;
        acc_d[int'(idx_q)*N +: N] = add_s_i;
        cr_d  = add_c_i;
        idx_d = idx_q + IW'(1);
        if (last) begin
          // Partial slices live in acc; sum_o only ever sees the complete result.
          sum_d   = acc_d;
          carry_d = add_c_i;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (acc_d[W-1] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign ovf_o   = ovf_q;
  assign busy_o  = (state_q == CALC);
  assign done_o  = (state_q == DONE);

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed bench for multiword_add_ctrl with a behavioural 4-bit adder in the loop.
module tb_multiword_add_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        sub_i;
  logic [15:0] op_a_i;
  logic [15:0] op_b_i;
  logic [3:0]  add_a_o;
  logic [3:0]  add_b_o;
  logic        add_c_o;
  logic [3:0]  add_s_i;
  logic        add_c_i;
  logic [15:0] sum_o;
  logic        carry_o;
  logic        ovf_o;
  logic        busy_o;
  logic        done_o;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [3:0]  cvec;

  multiword_add_ctrl #(.N(4), .WORDS(4)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .sub_i   (sub_i),
    .op_a_i  (op_a_i),
    .op_b_i  (op_b_i),
    .add_a_o (add_a_o),
    .add_b_o (add_b_o),
    .add_c_o (add_c_o),
    .add_s_i (add_s_i),
    .add_c_i (add_c_i),
    .sum_o   (sum_o),
    .carry_o (carry_o),
    .ovf_o   (ovf_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  assign {add_c_i, add_s_i} = {1'b0, add_a_o} + {1'b0, add_b_o} + {4'b0, add_c_o};

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues one operation, checks busy/done through CALC, leaves time just after the DONE edge.
  task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                        output logic [3:0] cv);
    start_i = 1'b1; sub_i = s; op_a_i = a; op_b_i = b;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy_in_calc", {31'b0, busy_o}, 32'd1);
      chk("no_done_in_calc", {31'b0, done_o}, 32'd0);
      cv[i] = add_c_o;
      tick();
    end
    chk("done_pulse", {31'b0, done_o}, 32'd1);
    chk("busy_low_done", {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; sub_i = 1'b0; op_a_i = '0; op_b_i = '0;
    #3;
    chk("rst_sum", {16'b0, sum_o}, 32'h0);
    chk("rst_flags", {27'b0, carry_o, ovf_o, busy_o, done_o, add_c_o}, 32'h0);
    chk("rst_add", {24'b0, add_a_o, add_b_o}, 32'h0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick();

    // 0x1234 + 0x0FFF
    start_i = 1'b1; sub_i = 1'b0; op_a_i = 16'h1234; op_b_i = 16'h0FFF;
    tick();
    start_i = 1'b0;
    chk("s0_add_a", {28'b0, add_a_o}, 32'h4);
    chk("s0_add_b", {28'b0, add_b_o}, 32'hF);
    chk("s0_add_c", {31'b0, add_c_o}, 32'h0);
    tick(); tick(); tick();
    chk("busy_4th", {31'b0, busy_o}, 32'd1);
    chk("no_done_4th", {31'b0, done_o}, 32'd0);
    tick();
    chk("done_5th", {31'b0, done_o}, 32'd1);
    chk("sum_1234_0fff", {16'b0, sum_o}, 32'h2233);
    chk("cy_ov_1234_0fff", {30'b0, carry_o, ovf_o}, 32'h0);
    tick();
    chk("done_single", {31'b0, done_o}, 32'd0);
    chk("idle_add_zero", {23'b0, add_a_o, add_b_o, add_c_o}, 32'h0);
    chk("sum_hold", {16'b0, sum_o}, 32'h2233);

    // 0xFFFF + 0x0001
    run_op(1'b0, 16'hFFFF, 16'h0001, cvec);
    chk("sum_ffff_1", {16'b0, sum_o}, 32'h0000);
    chk("cy_ov_ffff_1", {30'b0, carry_o, ovf_o}, 32'h2);
    chk("cchain_ffff_1", {28'b0, cvec}, 32'hE);
    tick();

    // 0x8000 - 0x0001
    run_op(1'b1, 16'h8000, 16'h0001, cvec);
    chk("sum_8000_m1", {16'b0, sum_o}, 32'h7FFF);
    chk("cy_ov_8000_m1", {30'b0, carry_o, ovf_o}, 32'h3);
    chk("cchain_8000_m1", {28'b0, cvec}, 32'h1);
    tick();

    // 0x7FFF + 0x0001
    run_op(1'b0, 16'h7FFF, 16'h0001, cvec);
    chk("sum_7fff_1", {16'b0, sum_o}, 32'h8000);
    chk("cy_ov_7fff_1", {30'b0, carry_o, ovf_o}, 32'h1);
    tick();

    // start pulsed mid-CALC with other operands is ignored
    start_i = 1'b1; sub_i = 1'b0; op_a_i = 16'h0102; op_b_i = 16'h0304;
    tick();
    start_i = 1'b0;
    tick();
    start_i = 1'b1; sub_i = 1'b1; op_a_i = 16'hFFFF; op_b_i = 16'hFFFF;
    tick();
    start_i = 1'b0;
    tick(); tick();
    chk("ign_done", {31'b0, done_o}, 32'd1);
    chk("ign_sum", {16'b0, sum_o}, 32'h0406);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ign_no_extra", {30'b0, busy_o, done_o}, 32'h0);
    end

    // reset in the 2nd CALC cycle
    start_i = 1'b1; sub_i = 1'b0; op_a_i = 16'h1234; op_b_i = 16'h0FFF;
    tick();
    start_i = 1'b0;
    tick();
    chk("pre_rst_add_a", {28'b0, add_a_o}, 32'h3);
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_sum", {16'b0, sum_o}, 32'h0);
    chk("mid_rst_flags", {27'b0, carry_o, ovf_o, busy_o, done_o, add_c_o}, 32'h0);
    chk("mid_rst_add", {24'b0, add_a_o, add_b_o}, 32'h0);
    tick();
    rst_n_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_quiet", {30'b0, busy_o, done_o}, 32'h0);
    end
    run_op(1'b0, 16'h0005, 16'h0003, cvec);
    chk("post_rst_sum", {16'b0, sum_o}, 32'h0008);
    tick();

    // back-to-back: start held across DONE
    start_i = 1'b1; sub_i = 1'b0; op_a_i = 16'h1111; op_b_i = 16'h2222;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    start_i = 1'b1; op_a_i = 16'h0001; op_b_i = 16'h0001;
    tick();
    chk("b2b_done1", {31'b0, done_o}, 32'd1);
    chk("b2b_sum1", {16'b0, sum_o}, 32'h3333);
    tick();
    start_i = 1'b0;
    chk("b2b_calc2", {30'b0, busy_o, done_o}, 32'h2);
    chk("b2b_sum_held", {16'b0, sum_o}, 32'h3333);
    tick(); tick(); tick(); tick();
    chk("b2b_done2", {31'b0, done_o}, 32'd1);
    chk("b2b_sum2", {16'b0, sum_o}, 32'h0002);
    chk("b2b_cy_ov2", {30'b0, carry_o, ovf_o}, 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
